way_age_tracker: RTL and testbench

- Per-set, per-way saturating age counters feeding the replacement victim selector; sits directly upstream of select_biggest.
- Cache hits and fills refresh the accessed way: its age goes to 0, every other way in the set ages by 1.
- The replacement path queries a set and gets back that set's flattened age vector one cycle later. The vector drives select_biggest's way_flatted_in, and select_biggest picks the oldest eligible way.
- A flush sweep clears all ages on cache invalidation.

---
 rtl/way_age_tracker_pkg.sv | 21 ++
 rtl/way_age_row_update.sv | 34 +++
 rtl/way_age_tracker.sv | 129 ++++++++++++
 tb/tb_way_age_tracker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/way_age_tracker_pkg.sv
// rtl/way_age_tracker_pkg.sv - shared types and constants for the way age tracker
//
// Purpose: FSM state encoding and the age saturation helper used by
// way_age_tracker and way_age_row_update.
// Ports: none (package).

package way_age_tracker_pkg;

  // Sweep controller states. IDLE accepts accesses; FLUSH clears one set per cycle.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tracker_state_e;

  // Largest value an age counter of the given width may hold (2^width - 1).
  // Ages stick at this value instead of wrapping back to young.
  function automatic int age_sat_value(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/way_age_row_update.sv
// rtl/way_age_row_update.sv - next-row age computation for one accessed set
//
// Purpose: given one set's flattened ages and the way being hit or filled,
// produce the updated row: the accessed way becomes 0, every other way ages
// by one and saturates at the maximum age.
// Ports:
//   row_in   flattened ages, way i in bits [i*W +: W]
//   way_in   accessed way index
//   row_out  updated flattened ages

module way_age_row_update
  import way_age_tracker_pkg::*;
#(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 16,
  parameter int WAY_PTR_WIDTH_IN_BITS    = 4
) (
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] row_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]            way_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] row_out
);

  localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
  localparam logic [W-1:0] AGE_MAX = W'(age_sat_value(W));

  for (genvar i = 0; i < NUM_WAY; i++) begin : g_way
    logic [W-1:0] age;
    assign age = row_in[i*W +: W];
    assign row_out[i*W +: W] = (way_in == WAY_PTR_WIDTH_IN_BITS'(i)) ? '0 :
                               (age == AGE_MAX)                      ? age :
                                                                       age + 1'b1;
  end

endmodule

// File: rtl/way_age_tracker.sv
// rtl/way_age_tracker.sv - per-set per-way saturating age counters for victim selection
//
// Purpose: holds the age array, applies hit/fill refreshes, answers age
// queries one cycle later and clears everything with a one-set-per-cycle
// flush sweep.
// Ports:
//   clk_in, reset_in                 clock, synchronous active-high reset
//   access_valid_in/_set_in/_way_in  hit or fill refresh request
//   access_ready_out                 high in IDLE, access accepted when valid & ready
//   query_valid_in, query_set_in     age read request
//   way_flatted_out, way_valid_out   registered query result, valid one cycle later
//   flush_in, busy_out               start clear sweep, sweep in progress

module way_age_tracker
  import way_age_tracker_pkg::*;
#(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 16,
  parameter int NUM_SET                  = 8,
  parameter int WAY_PTR_WIDTH_IN_BITS    = 4,
  parameter int SET_PTR_WIDTH_IN_BITS    = 3
) (
  input  logic                                        clk_in,
  input  logic                                        reset_in,
  input  logic                                        access_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]            access_set_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]            access_way_in,
  output logic                                        access_ready_out,
  input  logic                                        query_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]            query_set_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_out,
  output logic                                        way_valid_out,
  input  logic                                        flush_in,
  output logic                                        busy_out
);

  localparam int ROW_W = SINGLE_WAY_WIDTH_IN_BITS * NUM_WAY;
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);

  logic [ROW_W-1:0] age_q [NUM_SET];

  tracker_state_e                   state_q, state_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] sweep_ptr_q;
  logic [ROW_W-1:0]                 flat_q;
  logic                             valid_q;

  logic             access_set_ok, access_way_ok, query_set_ok;
  logic             access_fire;
  logic [ROW_W-1:0] access_row_cur, access_row_next;

  // Index range checks only exist when the pointer can name a nonexistent
  // set or way; with power-of-two sizes every index is legal.
  if ((1 << SET_PTR_WIDTH_IN_BITS) > NUM_SET) begin : g_set_chk
    assign access_set_ok = (access_set_in < SET_PTR_WIDTH_IN_BITS'(NUM_SET));
    assign query_set_ok  = (query_set_in  < SET_PTR_WIDTH_IN_BITS'(NUM_SET));
  end else begin : g_set_all
    assign access_set_ok = 1'b1;
    assign query_set_ok  = 1'b1;
  end

  if ((1 << WAY_PTR_WIDTH_IN_BITS) > NUM_WAY) begin : g_way_chk
    assign access_way_ok = (access_way_in < WAY_PTR_WIDTH_IN_BITS'(NUM_WAY));
  end else begin : g_way_all
    assign access_way_ok = 1'b1;
  end

  assign access_ready_out = (state_q == ST_IDLE);
  assign busy_out         = (state_q == ST_FLUSH);
  assign way_flatted_out  = flat_q;
  assign way_valid_out    = valid_q;

  assign access_fire    = access_valid_in && access_ready_out && access_set_ok && access_way_ok;
  assign access_row_cur = access_set_ok ? age_q[access_set_in] : '0;

  way_age_row_update #(
    .SINGLE_WAY_WIDTH_IN_BITS (SINGLE_WAY_WIDTH_IN_BITS),
    .NUM_WAY                  (NUM_WAY),
    .WAY_PTR_WIDTH_IN_BITS    (WAY_PTR_WIDTH_IN_BITS)
  ) u_row_update (
    .row_in  (access_row_cur),
    .way_in  (access_way_in),
    .row_out (access_row_next)
  );

  // Flush sweep controller. flush_in only matters in IDLE; the sweep ends
  // after the cycle that clears the last set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_in) state_d = ST_FLUSH;
      ST_FLUSH: if (sweep_ptr_q == LAST_SET) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      sweep_ptr_q <= '0;
      flat_q      <= '0;
      valid_q     <= 1'b0;
      for (int s = 0; s < NUM_SET; s++) begin
        age_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;

      // Query reads the array before this edge's writes land, so a
      // same-cycle access to the queried set is not visible.
      valid_q <= query_valid_in;
      if (query_valid_in) begin
        flat_q <= query_set_ok ? age_q[query_set_in] : '0;
      end

      if (state_q == ST_IDLE) begin
        if (access_fire) begin
          age_q[access_set_in] <= access_row_next;
        end
        if (flush_in) begin
          sweep_ptr_q <= '0;
        end
      end else begin
        age_q[sweep_ptr_q] <= '0;
        sweep_ptr_q        <= (sweep_ptr_q == LAST_SET) ? '0 : sweep_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_way_age_tracker.sv
// tb/tb_way_age_tracker.sv - self-checking bench for way_age_tracker

module tb_way_age_tracker;

  localparam int W  = 4;
  localparam int NW = 16;
  localparam int NS = 8;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        access_valid_in;
  logic [2:0]  access_set_in;
  logic [3:0]  access_way_in;
  logic        access_ready_out;
  logic        query_valid_in;
  logic [2:0]  query_set_in;
  logic [63:0] way_flatted_out;
  logic        way_valid_out;
  logic        flush_in;
  logic        busy_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] exp_q [$];
  logic [3:0]  m_age [NS][NW];
  bit          m_busy;
  int          m_ptr;
  logic [63:0] last_flat;

  always #5 clk_in = ~clk_in;

  way_age_tracker dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .access_valid_in  (access_valid_in),
    .access_set_in    (access_set_in),
    .access_way_in    (access_way_in),
    .access_ready_out (access_ready_out),
    .query_valid_in   (query_valid_in),
    .query_set_in     (query_set_in),
    .way_flatted_out  (way_flatted_out),
    .way_valid_out    (way_valid_out),
    .flush_in         (flush_in),
    .busy_out         (busy_out)
  );

  function automatic logic [63:0] model_row(input int s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[i*W +: W] = m_age[s][i];
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < NW; i++) m_age[s][i] = 4'h0;
    m_busy = 1'b0;
    m_ptr  = 0;
    exp_q.delete();
    last_flat = '0;
  endtask

  task automatic model_access(input int s, input int w);
    for (int j = 0; j < NW; j++) begin
      if (j == w) m_age[s][j] = 4'h0;
      else if (m_age[s][j] != 4'hf) m_age[s][j] = m_age[s][j] + 4'h1;
    end
  endtask

  // One clock of stimulus; checks handshake, status and the scoreboard.
  task automatic cycle(input bit acc_v, input int acc_s, input int acc_w,
                       input bit q_v, input int q_s, input bit fl);
    logic [63:0] exp;
    logic [2:0]  s3;
    logic [3:0]  w4;
    s3 = acc_s[2:0];
    w4 = acc_w[3:0];
    access_valid_in = acc_v;
    access_set_in   = s3;
    access_way_in   = w4;
    s3 = q_s[2:0];
    query_valid_in  = q_v;
    query_set_in    = s3;
    flush_in        = fl;
    if (q_v) exp_q.push_back(model_row(q_s));
    @(posedge clk_in);
    if (!m_busy) begin
      if (acc_v) model_access(acc_s, acc_w);
      if (fl) begin
        m_busy = 1'b1;
        m_ptr  = 0;
      end
    end else begin
      for (int i = 0; i < NW; i++) m_age[m_ptr][i] = 4'h0;
      if (m_ptr == NS - 1) m_busy = 1'b0;
      m_ptr = (m_ptr + 1) % NS;
    end
    #1;
    access_valid_in = 1'b0;
    query_valid_in  = 1'b0;
    flush_in        = 1'b0;
    vectors++;
    if (way_valid_out !== q_v) begin
      miscompares++;
      $display("FAIL way_valid: got %b expected %b", way_valid_out, q_v);
    end
    vectors++;
    if (q_v) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: got result %h expected a queued entry", way_flatted_out);
      end else begin
        exp = exp_q.pop_front();
        last_flat = exp;
        if (way_flatted_out !== exp) begin
          miscompares++;
          $display("FAIL query_data set %0d: got %h expected %h", q_s, way_flatted_out, exp);
        end
      end
    end else if (way_flatted_out !== last_flat) begin
      miscompares++;
      $display("FAIL flat_hold: got %h expected %h", way_flatted_out, last_flat);
    end
    vectors++;
    if (busy_out !== m_busy || access_ready_out !== !m_busy) begin
      miscompares++;
      $display("FAIL status: got busy=%b ready=%b expected busy=%b ready=%b",
               busy_out, access_ready_out, m_busy, !m_busy);
    end
  endtask

  task automatic check_flat(input string name, input logic [63:0] exp);
    vectors++;
    if (way_flatted_out !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, way_flatted_out, exp);
    end
  endtask

  task automatic do_reset();
    reset_in        = 1'b1;
    access_valid_in = 1'b0;
    query_valid_in  = 1'b0;
    flush_in        = 1'b0;
    @(posedge clk_in);
    model_reset();
    #1;
    reset_in = 1'b0;
    vectors++;
    if (way_valid_out !== 1'b0 || way_flatted_out !== 64'h0 ||
        busy_out !== 1'b0 || access_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b flat=%h busy=%b ready=%b expected 0 0 0 1",
               way_valid_out, way_flatted_out, busy_out, access_ready_out);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cycle(0, 0, 0, 1, 3, 0);
    check_flat("reset_query_set3", 64'h0);
  endtask

  task automatic test_single_access();
    cycle(1, 2, 5, 0, 0, 0);
    cycle(0, 0, 0, 1, 2, 0);
    check_flat("access_s2w5", 64'h1111_1111_1101_1111);
    cycle(0, 0, 0, 1, 6, 0);
    check_flat("untouched_s6", 64'h0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 3, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    check_flat("saturate_s1", 64'hffff_ffff_ffff_0ff1);
  endtask

  task automatic test_read_before_write();
    cycle(1, 4, 7, 1, 4, 0);
    check_flat("rbw_same_cycle", 64'h0);
    cycle(0, 0, 0, 1, 4, 0);
    check_flat("rbw_followup", 64'h1111_1111_0111_1111);
  endtask

  task automatic test_flush_held_access();
    int busy_cycles;
    busy_cycles = 0;
    cycle(1, 6, 1, 0, 0, 0);
    // flush pulse with the access already held: applied, then swept away
    cycle(1, 5, 2, 0, 0, 1);
    if (busy_out === 1'b1) busy_cycles++;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 5, 2, (i == 0), 6, 0);
      if (busy_out === 1'b1) busy_cycles++;
    end
    vectors++;
    if (busy_cycles != 8) begin
      miscompares++;
      $display("FAIL busy_length: got %0d cycles expected 8", busy_cycles);
    end
    // first IDLE cycle: held access accepted; same-cycle query sees the cleared set
    cycle(1, 5, 2, 1, 5, 0);
    check_flat("post_flush_s5_before", 64'h0);
    for (int s = 0; s < NS; s++) begin
      cycle(0, 0, 0, 1, s, 0);
      check_flat("post_flush_set", (s == 5) ? 64'h1111_1111_1111_1011 : 64'h0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    cycle(1, 0, 4, 0, 0, 0);
    cycle(1, 3, 9, 0, 0, 0);
    cycle(1, 7, 15, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    for (int s = 0; s < NS; s++) begin
      cycle(0, 0, 0, 1, s, 0);
      check_flat("reset_mid_sweep_set", 64'h0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      cycle(1, $urandom_range(0, NS - 1), $urandom_range(0, NW - 1),
            1, $urandom_range(0, NS - 1), 0);
    end
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_in        = 1'b0;
    access_valid_in = 1'b0;
    access_set_in   = '0;
    access_way_in   = '0;
    query_valid_in  = 1'b0;
    query_set_in    = '0;
    flush_in        = 1'b0;
    model_reset();
    @(negedge clk_in);
    test_reset();
    test_single_access();
    test_saturation();
    test_read_before_write();
    test_flush_held_access();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
